// File: rtl/phy_rx_serpar_align.sv
// N-lane serial-to-parallel receiver: per-lane comma hunt, word lock after BC_COUNT aligned commas, parallel word strobe.
// Optional feature macro: RX_RESYNC_EN (misaligned comma while ACTIVE drops lock and re-synchronises).
module phy_rx_serpar_align #(
  parameter int               NUM_LANES = 2,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
  parameter int               BC_COUNT  = 4
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  input  logic [NUM_LANES-1:0]          ser_in,
  output logic [NUM_LANES*WIDTH-1:0]    data_out,
  output logic [NUM_LANES-1:0]          valid_out,
  output logic [NUM_LANES-1:0]          active,
  output logic                          active_all
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int CC_W  = $clog2(BC_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CC_W-1:0]  CC_FULL  = CC_W'(BC_COUNT);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Comma counter saturates at BC_COUNT so it never wraps while locked.
  function automatic logic [CC_W-1:0] cc_inc(input logic [CC_W-1:0] c);
    if (c == CC_FULL) return c;
    else              return c + CC_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    state_t             state_q, state_d;
    logic [WIDTH-2:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   cand;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CC_W-1:0]    comma_cnt_q, comma_cnt_d, cc_next;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               active_q, active_d;
    logic               boundary, is_comma;

    assign cand     = {sr_q, ser_in[g]};
    assign is_comma = (cand == COMMA);
    assign boundary = (bit_cnt_q == LAST_BIT);
    assign cc_next  = cc_inc(comma_cnt_q);

    always_comb begin
      state_d     = state_q;
      sr_d        = cand[WIDTH-2:0];
      bit_cnt_d   = boundary ? '0 : bit_cnt_q + CNT_W'(1);
      comma_cnt_d = comma_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      active_d    = active_q;
      unique case (state_q)
        S_SEARCH: begin
          // Bit counter is meaningless until a comma fixes the word phase.
          bit_cnt_d = '0;
          if (is_comma) begin
            comma_cnt_d = CC_W'(1);
            if (BC_COUNT == 1) begin
              state_d  = S_ACTIVE;
              active_d = 1'b1;
            end else begin
              state_d = S_SYNC;
            end
          end
        end
        S_SYNC: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_d = cc_next;
              if (cc_next == CC_FULL) begin
                state_d  = S_ACTIVE;
                active_d = 1'b1;
              end
            end else begin
              comma_cnt_d = '0;
              state_d     = S_SEARCH;
            end
          end
        end
        S_ACTIVE: begin
          if (boundary && !is_comma) begin
            data_d  = cand;
            valid_d = 1'b1;
          end
`ifdef RX_RESYNC_EN
          else if (!boundary && is_comma) begin
            active_d    = 1'b0;
            bit_cnt_d   = '0;
            comma_cnt_d = CC_W'(1);
            state_d     = S_SYNC;
          end
`endif
        end
        default: begin
          state_d  = S_SEARCH;
          active_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk_32f) begin
      if (reset) begin
        state_q     <= S_SEARCH;
        sr_q        <= '0;
        bit_cnt_q   <= '0;
        comma_cnt_q <= '0;
        data_q      <= '0;
        valid_q     <= 1'b0;
        active_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        sr_q        <= sr_d;
        bit_cnt_q   <= bit_cnt_d;
        comma_cnt_q <= comma_cnt_d;
        data_q      <= data_d;
        valid_q     <= valid_d;
        active_q    <= active_d;
      end
    end

    assign data_out[g*WIDTH +: WIDTH] = data_q;
    assign valid_out[g]               = valid_q;
    assign active[g]                  = active_q;
  end

  assign active_all = &active;

endmodule
